kamus_dmem_ctrl: RTL and testbench
==================================

// Module: kamus_dmem_ctrl
// PURPOSE
//  Sequences every load/store from the MEM stage onto the L1D port: req/gnt/rvalid handshake, byte enables,
//  read-data alignment/sign-extension, misalign detection. Sits between the LSU (EX/MEM reg side) and L1D.
//  Holds the pipeline via stall_o until the access completes, so L1D may take any number of cycles.
// PARAMETERS
//  ADDR_W       32  byte-address width for req_addr_i and mem_addr_o
//  TIMEOUT_CYC  64  cycles in ST_WAIT before a bus-error response (used only with KAMUS_DMEM_TIMEOUT_EN)
// PORTS
//  clk_i          in   1       single clock; all state updates on posedge
//  rst_i          in   1       reset, synchronous, active-high
//  req_valid_i    in   1       MEM stage holds a load/store; operands held stable while stall_o=1
//  req_we_i       in   1       1=store, 0=load
//  req_size_i     in   2       00=byte 01=half 10=word (11 treated as word)
//  req_unsigned_i in   1       load zero-extends (LBU/LHU)
//  req_addr_i     in   ADDR_W  byte address (ALU result)
//  req_wdata_i    in   32      store data (rs2), LSB-aligned
//  rsp_valid_o    out  1       1-cycle pulse: access done
//  rsp_rdata_o    out  32      aligned/extended load data; 0 for stores and errors
//  rsp_err_o      out  1       with rsp_valid_o: misaligned or bus error
//  stall_o        out  1       freeze PC and IF..MEM stages
//  mem_req_o      out  1       L1D request; held until mem_gnt_i
//  mem_we_o       out  1       L1D write enable
//  mem_be_o       out  4       byte enables
//  mem_addr_o     out  ADDR_W  word-aligned address ([1:0]=00)
//  mem_wdata_o    out  32      lane-replicated store data
//  mem_gnt_i      in   1       L1D accepted request this cycle
//  mem_rvalid_i   in   1       L1D response valid (loads and stores)
//  mem_rdata_i    in   32      L1D read word
//  mem_err_i      in   1       L1D bus error, qualified by mem_rvalid_i
// BEHAVIOUR
//  - Reset: state=ST_IDLE; every registered output 0; request latches 0; timeout counter 0.
//  - FSM: ST_IDLE, ST_REQ, ST_WAIT, ST_RESP.
//    IDLE: req_valid_i & aligned -> latch op, go REQ. req_valid_i & misaligned -> RESP with err, no L1D access.
//    REQ: mem_req_o=1; gnt&rvalid same cycle -> RESP; gnt only -> WAIT; otherwise stay.
//    WAIT: rvalid -> RESP.
//    RESP: rsp_valid_o=1 for exactly 1 cycle -> IDLE.
//  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
//  - Min latency: accept cycle 0; mem_req_o cycle 1 (gnt); rvalid cycle 2; rsp_valid_o cycle 3.
//  - stall_o = req_valid_i & ~rsp_valid_o (combinational). Pipeline advances in the RESP cycle.
//    req_valid_i seen in that cycle is the next op, accepted next cycle in IDLE.
//  - Byte enables: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111.
//  - mem_wdata_o: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
//  - mem_req_o/we/be/addr/wdata are registered and constant for the whole REQ state.
//  - Load data: shift mem_rdata_i right by 8*a[1:0], mask to size, sign-extend unless req_unsigned_i.
//    Captured on rvalid.
//  - mem_err_i on rvalid -> rsp_err_o=1, rsp_rdata_o=0.
//  - mem_rvalid_i outside WAIT/REQ is ignored. rst_i mid-access drops the access; no response is issued.
// CONFIGURATION
//  KAMUS_DMEM_TIMEOUT_EN defined:
//    - Counter clears on entering WAIT and counts each WAIT cycle.
//    - Reaching TIMEOUT_CYC without rvalid -> RESP with rsp_err_o=1, rsp_rdata_o=0.
//    - A late rvalid arriving in IDLE is ignored.
//  Undefined: no counter logic; WAIT lasts until rvalid, without limit.
// STRUCTURE
//  kamus_pkg:
//    - mem_size_e {MEM_B, MEM_H, MEM_W}
//    - dmem_state_e {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP}
//  Sub-module kamus_dmem_align (combinational):
//    - addr/size/wdata -> be, lane data, misaligned
//    - rdata/offset/size/unsigned -> load value
// TESTING
//  1 LW 0x100, gnt immediate, rvalid next, rdata=0xDEADBEEF -> rsp_valid_o at cycle 3, rdata 0xDEADBEEF, stall_o 1 for cycles 0-2.
//  2 LB 0x103, rdata=0x80112233 -> rdata 0xFFFFFF80; LBU same -> 0x00000080; mem_addr_o=0x100, be=1000.
//  3 SH 0x102, wdata=0x0000ABCD -> mem_be_o=1100, mem_wdata_o=0xABCDABCD, mem_we_o=1; gnt held off 3 cycles -> mem_req_o stable.
//  4 LW 0x101 -> rsp_err_o=1 one cycle after accept, mem_req_o never asserted.
//  5 LW with rvalid+mem_err_i -> rsp_err_o=1, rdata 0. Back-to-back SW then LW -> both complete in order, no lost op.
//  6 rst_i in WAIT -> next cycle all outputs 0, state IDLE. With KAMUS_DMEM_TIMEOUT_EN and no rvalid -> err after 64 WAIT cycles.

Source files
------------

// File: rtl/kamus_pkg.sv
// Shared types for the KAMUS data-memory controller and its alignment helper.
package kamus_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } dmem_state_e;

    // The unused encoding 2'b11 behaves as a word access.
    function automatic mem_size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return MEM_B;
            2'b01:   return MEM_H;
            default: return MEM_W;
        endcase
    endfunction

endpackage

// File: rtl/kamus_dmem_align.sv
// Combinational lane logic: byte enables, store replication, misalign detect and
// load extraction with sign/zero extension.
module kamus_dmem_align
    import kamus_pkg::*;
(
    input  logic [1:0]  offset,
    input  mem_size_e   size,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        is_unsigned,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        misaligned,
    output logic [31:0] load_value
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = rdata >> {offset, 3'b000};
        be         = 4'b1111;
        lane_wdata = wdata;
        misaligned = 1'b0;
        load_value = shifted;
        case (size)
            MEM_B: begin
                be         = 4'b0001 << offset;
                lane_wdata = {4{wdata[7:0]}};
                load_value = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            MEM_H: begin
                be         = 4'b0011 << offset;
                lane_wdata = {2{wdata[15:0]}};
                misaligned = offset[0];
                load_value = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            default: misaligned = |offset;
        endcase
    end

endmodule

// File: rtl/kamus_dmem_ctrl.sv
// MEM-stage load/store sequencer onto the L1D req/gnt/rvalid port.
// Optional WAIT-state bus timeout is enabled with KAMUS_DMEM_TIMEOUT_EN.
module kamus_dmem_ctrl
    import kamus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_err_i
);

    dmem_state_e       state_q, state_d;
    logic              mem_req_q, mem_we_q;
    logic [3:0]        mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [1:0]        off_q;
    mem_size_e         size_q;
    logic              uns_q;
    logic              rsp_valid_q;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              accept, capture, timeout;

    logic              in_idle;
    logic [1:0]        al_offset;
    mem_size_e         al_size;
    logic              al_uns;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata, al_load;
    logic              al_misaligned;

    // In IDLE the helper decodes the incoming request; afterwards it works on the latched op.
    assign in_idle   = (state_q == ST_IDLE);
    assign al_offset = in_idle ? req_addr_i[1:0] : off_q;
    assign al_size   = in_idle ? decode_size(req_size_i) : size_q;
    assign al_uns    = in_idle ? req_unsigned_i : uns_q;

    kamus_dmem_align u_align (
        .offset      (al_offset),
        .size        (al_size),
        .wdata       (req_wdata_i),
        .rdata       (mem_rdata_i),
        .is_unsigned (al_uns),
        .be          (al_be),
        .lane_wdata  (al_wdata),
        .misaligned  (al_misaligned),
        .load_value  (al_load)
    );

`ifdef KAMUS_DMEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    logic [CntW-1:0] cnt_q;

    // Held at zero outside WAIT so every WAIT entry starts a fresh count.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != ST_WAIT) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == ST_WAIT) && (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        accept      = 1'b0;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (al_misaligned) begin
                        state_d     = ST_RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = ST_REQ;
                        accept  = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_d = mem_rvalid_i ? ST_RESP : ST_WAIT;
                    capture = mem_rvalid_i;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = ST_RESP;
                    capture = 1'b1;
                end else if (timeout) begin
                    state_d     = ST_RESP;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (capture) begin
            rsp_err_d   = mem_err_i;
            rsp_rdata_d = (mem_err_i || mem_we_q) ? '0 : al_load;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            off_q       <= '0;
            size_q      <= MEM_B;
            uns_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= (state_d == ST_REQ);
            rsp_valid_q <= (state_d == ST_RESP);
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                mem_we_q    <= req_we_i;
                mem_be_q    <= al_be;
                mem_addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                mem_wdata_q <= al_wdata;
                off_q       <= req_addr_i[1:0];
                size_q      <= al_size;
                uns_q       <= req_unsigned_i;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign stall_o     = req_valid_i & ~rsp_valid_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_kamus_dmem_ctrl.sv
// Self-checking bench for kamus_dmem_ctrl: directed scenarios plus randomized ops
// against a byte-addressed memory model. KAMUS_DMEM_TIMEOUT_EN adds the timeout scenario.
module tb_kamus_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, stall;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    kamus_dmem_ctrl #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .stall_o        (stall),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .mem_err_i      (mem_err)
    );

    // L1D responder: grant after cfg_gd waiting cycles, respond cfg_rd cycles after grant.
    int          cfg_gd = 0, cfg_rd = 1;
    bit          cfg_err = 1'b0;
    int          req_cycles = 0, req_changes = 0;
    logic        g_we;
    logic [3:0]  g_be;
    logic [31:0] g_addr, g_wdata;
    logic [31:0] l1_mem [0:255];

    task l1_respond();
        mem_rvalid = 1'b1;
        mem_err    = cfg_err;
        mem_rdata  = $urandom;
        if (!cfg_err && g_we) begin
            for (int b = 0; b < 4; b++)
                if (g_be[b]) l1_mem[g_addr[9:2]][8*b +: 8] = g_wdata[8*b +: 8];
        end else if (!cfg_err) begin
            mem_rdata = l1_mem[g_addr[9:2]];
        end
    endtask

    initial begin
        int   gcnt, pcnt;
        bit   pend, prev_req;
        logic [40:0] prev_bus;
        gcnt = 0; pcnt = 0; pend = 0; prev_req = 0; prev_bus = '0;
        for (int i = 0; i < 256; i++) l1_mem[i] = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
        forever begin
            @(posedge clk); #1;
            mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = '0;
            if (pend) begin
                pcnt--;
                if (pcnt == 0) begin
                    l1_respond();
                    pend = 0;
                end
            end
            if (mem_req) begin
                req_cycles++;
                if (prev_req && {mem_we, mem_be, mem_addr} !== prev_bus) req_changes++;
                prev_bus = {mem_we, mem_be, mem_addr};
                prev_req = 1;
                if (gcnt >= cfg_gd) begin
                    mem_gnt = 1; gcnt = 0; prev_req = 0;
                    g_we = mem_we; g_be = mem_be; g_addr = mem_addr; g_wdata = mem_wdata;
                    if (cfg_rd == 0) l1_respond();
                    else begin
                        pend = 1;
                        pcnt = cfg_rd;
                    end
                end else begin
                    gcnt++;
                end
            end else begin
                prev_req = 0;
            end
        end
    end

    // Reference model: flat byte-addressed memory, accesses of 1/2/4 bytes.
    logic [7:0] ref_mem [0:1023];

    function automatic int model_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (a % model_bytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                               input logic [31:0] a);
        int          n;
        logic [31:0] v;
        n = model_bytes(sz);
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[10'(a + 32'(i))]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic void model_store(input logic [1:0] sz, input logic [31:0] a,
                                        input logic [31:0] wd);
        for (int i = 0; i < model_bytes(sz); i++) ref_mem[10'(a + 32'(i))] = wd[8*i +: 8];
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        return 4'(((1 << model_bytes(sz)) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_lane(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % model_bytes(sz)) +: 8];
        return v;
    endfunction

    // Present one op (from #1 after a posedge) and wait, bounded, for its response.
    task automatic run_op(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic [7:0] stall_v);
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        lat = -1; rd = 'x; er = 'x; stall_v = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c < 8) stall_v[c] = stall;
            if (rsp_valid) begin
                lat = c; rd = rsp_rdata; er = rsp_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic preload_word(input logic [31:0] a, input logic [31:0] w);
        int lat; logic [31:0] rd; logic er; logic [7:0] sv;
        run_op(1, 2'd2, 0, a, w, lat, rd, er, sv);
        req_valid = 0;
        model_store(2'd2, a, w);
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_err, mem_req, mem_we, stall} !== 5'b0)
            $display("FAIL reset_flags got %b exp 00000", {rsp_valid, rsp_err, mem_req, mem_we, stall});
        else n_pass++;
        n_checks++;
        if ({rsp_rdata, mem_be, mem_addr, mem_wdata} !== 100'b0)
            $display("FAIL reset_data got %h/%h/%h/%h exp 0", rsp_rdata, mem_be, mem_addr, mem_wdata);
        else n_pass++;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_lw();
        int lat; logic [31:0] rd; logic er; logic [7:0] sv;
        preload_word(32'h100, 32'hDEADBEEF);
        cfg_gd = 0; cfg_rd = 1;
        run_op(0, 2'd2, 0, 32'h100, 32'h0, lat, rd, er, sv);
        req_valid = 0;
        n_checks++; if (lat !== 3) $display("FAIL lw_latency got %0d exp 3", lat); else n_pass++;
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_rdata got %h exp deadbeef", rd); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL lw_err got %b exp 0", er); else n_pass++;
        n_checks++; if (sv[3:0] !== 4'b0111) $display("FAIL lw_stall got %b exp 0111", sv[3:0]); else n_pass++;
        n_checks++;
        if ({g_we, g_be, g_addr} !== {1'b0, 4'hF, 32'h100})
            $display("FAIL lw_bus got we=%b be=%b addr=%h exp 0/1111/100", g_we, g_be, g_addr);
        else n_pass++;
    endtask

    task automatic test_lb();
        int lat; logic [31:0] rd; logic er; logic [7:0] sv;
        preload_word(32'h100, 32'h80112233);
        run_op(0, 2'd0, 0, 32'h103, 32'h0, lat, rd, er, sv);
        n_checks++; if (rd !== 32'hFFFFFF80) $display("FAIL lb_rdata got %h exp ffffff80", rd); else n_pass++;
        n_checks++;
        if ({g_be, g_addr} !== {4'b1000, 32'h100})
            $display("FAIL lb_bus got be=%b addr=%h exp 1000/100", g_be, g_addr);
        else n_pass++;
        run_op(0, 2'd0, 1, 32'h103, 32'h0, lat, rd, er, sv);
        n_checks++; if (rd !== 32'h00000080) $display("FAIL lbu_rdata got %h exp 00000080", rd); else n_pass++;
        run_op(0, 2'd1, 0, 32'h102, 32'h0, lat, rd, er, sv);
        req_valid = 0;
        n_checks++; if (rd !== 32'hFFFF8011) $display("FAIL lh_rdata got %h exp ffff8011", rd); else n_pass++;
    endtask

    task automatic test_sh();
        int lat, rc0, ch0; logic [31:0] rd; logic er; logic [7:0] sv;
        cfg_gd = 3; cfg_rd = 1;
        rc0 = req_cycles; ch0 = req_changes;
        run_op(1, 2'd1, 0, 32'h102, 32'h0000ABCD, lat, rd, er, sv);
        req_valid = 0;
        model_store(2'd1, 32'h102, 32'h0000ABCD);
        n_checks++;
        if ({g_we, g_be, g_wdata} !== {1'b1, 4'b1100, 32'hABCDABCD})
            $display("FAIL sh_bus got we=%b be=%b wd=%h exp 1/1100/abcdabcd", g_we, g_be, g_wdata);
        else n_pass++;
        n_checks++; if (req_cycles - rc0 !== 4) $display("FAIL sh_req_cycles got %0d exp 4", req_cycles - rc0); else n_pass++;
        n_checks++; if (req_changes - ch0 !== 0) $display("FAIL sh_req_stable got %0d exp 0", req_changes - ch0); else n_pass++;
        n_checks++; if (lat !== 6) $display("FAIL sh_latency got %0d exp 6", lat); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL sh_rdata got %h exp 0", rd); else n_pass++;
        cfg_gd = 0;
        run_op(0, 2'd2, 0, 32'h100, 32'h0, lat, rd, er, sv);
        req_valid = 0;
        n_checks++;
        if (rd !== model_load(2'd2, 0, 32'h100)) $display("FAIL sh_readback got %h exp %h", rd, model_load(2'd2, 0, 32'h100));
        else n_pass++;
    endtask

    task automatic test_misaligned();
        int lat, rc0; logic [31:0] rd; logic er; logic [7:0] sv;
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs = '{32'h101, 32'h103, 32'h102};
        sizes = '{2'd2, 2'd1, 2'd3};
        rc0 = req_cycles;
        for (int i = 0; i < 3; i++) begin
            run_op(i == 1, sizes[i], 0, addrs[i], 32'h12345678, lat, rd, er, sv);
            req_valid = 0;
            n_checks++;
            if ({lat, er, rd} !== {32'd1, 1'b1, 32'h0})
                $display("FAIL misalign_%0d got lat=%0d err=%b rd=%h exp 1/1/0", i, lat, er, rd);
            else n_pass++;
        end
        repeat (3) @(posedge clk); #1;
        n_checks++; if (req_cycles - rc0 !== 0) $display("FAIL misalign_no_req got %0d exp 0", req_cycles - rc0); else n_pass++;
    endtask

    task automatic test_bus_err();
        int lat; logic [31:0] rd; logic er; logic [7:0] sv;
        cfg_err = 1;
        run_op(0, 2'd2, 0, 32'h104, 32'h0, lat, rd, er, sv);
        req_valid = 0;
        cfg_err = 0;
        n_checks++;
        if ({lat, er, rd} !== {32'd3, 1'b1, 32'h0})
            $display("FAIL bus_err got lat=%0d err=%b rd=%h exp 3/1/0", lat, er, rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat0, lat1; logic [31:0] rd0, rd1, wd; logic er0, er1; logic [7:0] sv0, sv1;
        wd = $urandom;
        run_op(1, 2'd2, 0, 32'h108, wd, lat0, rd0, er0, sv0);
        run_op(0, 2'd2, 0, 32'h108, 32'h0, lat1, rd1, er1, sv1);
        req_valid = 0;
        model_store(2'd2, 32'h108, wd);
        n_checks++;
        if ({lat0, er0, rd0} !== {32'd3, 1'b0, 32'h0})
            $display("FAIL b2b_store got lat=%0d err=%b rd=%h exp 3/0/0", lat0, er0, rd0);
        else n_pass++;
        n_checks++;
        if ({lat1, er1, rd1} !== {32'd3, 1'b0, wd})
            $display("FAIL b2b_load got lat=%0d err=%b rd=%h exp 3/0/%h", lat1, er1, rd1, wd);
        else n_pass++;
        n_checks++; if (sv1[0] !== 1'b1) $display("FAIL b2b_stall got %b exp 1", sv1[0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        cfg_gd = 0; cfg_rd = 20;
        req_valid = 1; req_we = 0; req_size = 2'd2; req_unsigned = 0;
        req_addr = 32'h100; req_wdata = '0;
        repeat (3) @(posedge clk); #1;
        rst = 1; req_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_err, mem_req, mem_we, stall, rsp_rdata, mem_be, mem_addr, mem_wdata} !== 105'b0)
            $display("FAIL rst_mid_outputs got req=%b rsp=%b rd=%h be=%b addr=%h", mem_req, rsp_valid, rsp_rdata, mem_be, mem_addr);
        else n_pass++;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rst_mid_no_rsp got %b exp 0", seen); else n_pass++;
        @(posedge clk); #1;
        cfg_rd = 1;
    endtask

`ifdef KAMUS_DMEM_TIMEOUT_EN
    task automatic test_timeout();
        int lat; logic [31:0] rd; logic er; logic [7:0] sv; bit seen;
        cfg_gd = 0; cfg_rd = 100;
        run_op(0, 2'd2, 0, 32'h100, 32'h0, lat, rd, er, sv);
        req_valid = 0;
        n_checks++;
        if ({lat, er, rd} !== {32'd66, 1'b1, 32'h0})
            $display("FAIL timeout got lat=%0d err=%b rd=%h exp 66/1/0", lat, er, rd);
        else n_pass++;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL timeout_late_rvalid got %b exp 0", seen); else n_pass++;
        @(posedge clk); #1;
        cfg_rd = 1;
    endtask
`endif

    task automatic test_random();
        int lat, exp_lat; logic [31:0] rd, exp_rd, a, wd; logic er; logic [7:0] sv;
        bit we, uns, mis; logic [1:0] sz;
        for (int i = 0; i < 64; i++) preload_word(32'(i * 4), $urandom);
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3)); a = 32'($urandom_range(0, 255)); wd = $urandom;
            cfg_gd = $urandom_range(0, 3); cfg_rd = $urandom_range(0, 3);
            cfg_err = ($urandom_range(0, 7) == 0);
            mis     = model_misaligned(sz, a);
            exp_lat = mis ? 1 : 2 + cfg_gd + cfg_rd;
            exp_rd  = (!mis && !cfg_err && !we) ? model_load(sz, uns, a) : 32'h0;
            run_op(we, sz, uns, a, wd, lat, rd, er, sv);
            if ($urandom_range(0, 1) == 0) begin
                req_valid = 0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            n_checks++;
            if ({lat, er, rd} !== {exp_lat, mis | cfg_err, exp_rd})
                $display("FAIL rand_%0d_rsp got lat=%0d err=%b rd=%h exp %0d/%b/%h", i, lat, er, rd, exp_lat, mis | cfg_err, exp_rd);
            else n_pass++;
            if (!mis) begin
                n_checks++;
                if ({g_we, g_be, g_addr} !== {we, model_be(sz, a), a[31:2], 2'b00})
                    $display("FAIL rand_%0d_bus got we=%b be=%b addr=%h exp %b/%b/%h", i, g_we, g_be, g_addr, we, model_be(sz, a), {a[31:2], 2'b00});
                else n_pass++;
                if (we) begin
                    n_checks++;
                    if (g_wdata !== model_lane(sz, wd))
                        $display("FAIL rand_%0d_wdata got %h exp %h", i, g_wdata, model_lane(sz, wd));
                    else n_pass++;
                    if (!cfg_err) model_store(sz, a, wd);
                end
            end
        end
        req_valid = 0;
        cfg_err = 0;
    endtask

    initial begin
        rst = 1; req_valid = 0; req_we = 0; req_size = '0; req_unsigned = 0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_misaligned();
        test_bus_err();
        test_back_to_back();
        test_reset_mid();
`ifdef KAMUS_DMEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
